// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The default divisor gives 9600 Hz from the 100 MHz system clock.
package clkdiv_pkg;

  localparam int CNT_W_DEF     = 16;
  localparam int DIV_RESET_DEF = 5208;
  localparam int OVS_LOG2_DEF  = 4;

  localparam int unsigned SYS_CLK_HZ = 32'd100_000_000;

  // Divisor (input cycles per half-period) for a target output frequency,
  // rounded to nearest and never below 1.
  function automatic int unsigned div_for_freq(input int unsigned f_out_hz);
    int unsigned d;
    if ((f_out_hz == 32'd0) || (f_out_hz > 32'h7FFF_FFFF)) begin
      d = 32'd1;
    end else begin
      d = (SYS_CLK_HZ + f_out_hz) / (32'd2 * f_out_hz);
    end
    if (d == 32'd0) begin
      d = 32'd1;
    end else begin
      d = d;
    end
    return d;
  endfunction

endpackage

// File: rtl/prog_clock_divider_if.sv
// Divisor load handshake: the master offers div_in with div_valid, and the
// divider accepts it while div_ready is high.
interface prog_clock_divider_if
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic [CNT_W-1:0] div_in;
  logic             div_valid;
  logic             div_ready;

  modport master (output div_in, output div_valid, input div_ready);
  modport slave  (input div_in, input div_valid, output div_ready);
endinterface

// File: rtl/clkdiv_div_stage.sv
// Divisor staging: accepts a new divisor over valid/ready, clamps 0 to 1,
// holds it in a one-deep pending register and swaps it into the active
// divisor only on a half-period boundary (wrap or sync), or straight away
// while counting is disabled. A transfer landing exactly on a boundary goes
// directly to the active divisor and never occupies the pending slot.
module clkdiv_div_stage
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync,
  input  logic                  wrap,
  prog_clock_divider_if.slave   div_bus,
  output logic [CNT_W-1:0]      div_q
);

  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] DIV_RESET_V = CNT_W'(DIV_RESET);

  logic [CNT_W-1:0] div_q_r;
  logic [CNT_W-1:0] pend_q_r;
  logic             pend_v_r;
  logic [CNT_W-1:0] div_in_clamped_s;
  logic             xfer_s;
  logic             boundary_s;

  // Ready depends only on the pending flag, so there is no input-to-ready path.
  assign div_bus.div_ready = !pend_v_r;
  assign div_q             = div_q_r;

  // Handshake decode, zero clamp and boundary detect.
  always_comb begin
    xfer_s     = div_bus.div_valid && !pend_v_r;
    boundary_s = sync || wrap;
    if (div_bus.div_in == CNT_ZERO) begin
      div_in_clamped_s = CNT_ONE;
    end else begin
      div_in_clamped_s = div_bus.div_in;
    end
  end

  // Active/pending divisor registers; pending is discarded on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q_r  <= DIV_RESET_V;
      pend_q_r <= DIV_RESET_V;
      pend_v_r <= 1'b0;
    end else if (pend_v_r && (boundary_s || !en)) begin
      div_q_r  <= pend_q_r;
      pend_v_r <= 1'b0;
    end else if (xfer_s && boundary_s) begin
      div_q_r  <= div_in_clamped_s;
    end else if (xfer_s) begin
      pend_q_r <= div_in_clamped_s;
      pend_v_r <= 1'b1;
    end else begin
      div_q_r  <= div_q_r;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable clock divider: 50%-duty clk_out with a half-period of
// div_q input cycles, plus one-cycle tick (every toggle) and rise (0->1)
// strobes. sync restarts the phase with clk_out low.
// Optional feature macro: CLKDIV_OVS_EN adds the ovs_tick oversample strobe
// and the OVS_LOG2 parameter; without it both are absent.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DIV_RESET = DIV_RESET_DEF
`ifdef CLKDIV_OVS_EN
  ,
  parameter int OVS_LOG2  = OVS_LOG2_DEF
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                sync,
  prog_clock_divider_if.slave div_bus,
`ifdef CLKDIV_OVS_EN
  output logic                ovs_tick,
`endif
  output logic                clk_out,
  output logic                tick,
  output logic                rise
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_q_s;
  logic             wrap_s;

  clkdiv_div_stage #(
    .CNT_W     (CNT_W),
    .DIV_RESET (DIV_RESET)
  ) u_div_stage (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .wrap    (wrap_s),
    .div_bus (div_bus),
    .div_q   (div_q_s)
  );

  // Half-period ends on the last enabled cycle of the active divisor.
  always_comb begin
    wrap_s = en && (cnt_r == (div_q_s - CNT_ONE));
  end

  // Half-period counter and output flops; sync beats wrap beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r   <= CNT_ZERO;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      rise    <= 1'b0;
    end else if (sync) begin
      cnt_r   <= CNT_ZERO;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      rise    <= 1'b0;
    end else if (wrap_s) begin
      cnt_r   <= CNT_ZERO;
      clk_out <= !clk_out;
      tick    <= 1'b1;
      rise    <= !clk_out;
    end else if (en) begin
      cnt_r   <= cnt_r + CNT_ONE;
      tick    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      tick    <= 1'b0;
      rise    <= 1'b0;
    end
  end

`ifdef CLKDIV_OVS_EN
  logic [CNT_W-1:0] ovs_cnt_r;
  logic [CNT_W-1:0] ovs_div_s;
  logic             ovs_wrap_s;

  // Oversample period is the divisor scaled down, never below one cycle.
  always_comb begin
    ovs_div_s = div_q_s >> OVS_LOG2;
    if (ovs_div_s == CNT_ZERO) begin
      ovs_div_s = CNT_ONE;
    end else begin
      ovs_div_s = ovs_div_s;
    end
    ovs_wrap_s = (ovs_cnt_r == (ovs_div_s - CNT_ONE));
  end

  // Oversample counter, re-aligned to every main wrap and to sync.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovs_cnt_r <= CNT_ZERO;
      ovs_tick  <= 1'b0;
    end else if (sync) begin
      ovs_cnt_r <= CNT_ZERO;
      ovs_tick  <= 1'b0;
    end else if (en && wrap_s) begin
      ovs_cnt_r <= CNT_ZERO;
      ovs_tick  <= ovs_wrap_s;
    end else if (en && ovs_wrap_s) begin
      ovs_cnt_r <= CNT_ZERO;
      ovs_tick  <= 1'b1;
    end else if (en) begin
      ovs_cnt_r <= ovs_cnt_r + CNT_ONE;
      ovs_tick  <= 1'b0;
    end else begin
      ovs_tick  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider with DIV_RESET=4: directed scenarios with
// hand-counted half-period lengths, then randomized traffic, all checked
// every cycle against a behavioural model of elapsed cycles per half-period.
module tb_prog_clock_divider;
  import clkdiv_pkg::*;

  logic clk;
  logic reset;
  logic en;
  logic sync;
  logic clk_out;
  logic tick;
  logic rise;
`ifdef CLKDIV_OVS_EN
  logic ovs_tick;
`endif

  int errors = 0;
  int checks = 0;

  prog_clock_divider_if #(.CNT_W(16)) div_bus ();

  prog_clock_divider #(
    .CNT_W     (16),
    .DIV_RESET (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .div_bus  (div_bus),
`ifdef CLKDIV_OVS_EN
    .ovs_tick (ovs_tick),
`endif
    .clk_out  (clk_out),
    .tick     (tick),
    .rise     (rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_elapsed;   // enabled cycles spent in the current half-period
  int m_D;         // active half-period length
  int m_pend;
  bit m_pend_v;
  bit m_clk, m_tick, m_rise;
  int m_ovs_cnt;
  bit m_ovs_tick;

  task automatic model_reset();
    m_elapsed = 0; m_D = 4; m_pend = 4; m_pend_v = 1'b0;
    m_clk = 1'b0; m_tick = 1'b0; m_rise = 1'b0;
    m_ovs_cnt = 0; m_ovs_tick = 1'b0;
  endtask

  // Advance one clock using the inputs that the coming edge will sample.
  task automatic model_step();
    bit xfer, wrap, bnd;
    int val, ovsd;
    xfer = div_bus.div_valid && !m_pend_v;
    val  = (div_bus.div_in == 16'd0) ? 1 : int'(div_bus.div_in);
    wrap = en && ((m_elapsed + 1) == m_D);
    bnd  = sync || wrap;
    ovsd = m_D / 16;
    if (ovsd < 1) ovsd = 1;
    if (sync) begin
      m_ovs_cnt = 0; m_ovs_tick = 1'b0;
    end else if (en) begin
      m_ovs_tick = ((m_ovs_cnt + 1) == ovsd);
      m_ovs_cnt  = (wrap || m_ovs_tick) ? 0 : (m_ovs_cnt + 1) % 65536;
    end else begin
      m_ovs_tick = 1'b0;
    end
    if (m_pend_v && (bnd || !en)) begin
      m_D = m_pend; m_pend_v = 1'b0;
    end else if (xfer && bnd) begin
      m_D = val;
    end else if (xfer) begin
      m_pend = val; m_pend_v = 1'b1;
    end
    if (sync) begin
      m_elapsed = 0; m_clk = 1'b0; m_tick = 1'b0; m_rise = 1'b0;
    end else if (wrap) begin
      m_elapsed = 0; m_clk = !m_clk; m_tick = 1'b1; m_rise = m_clk;
    end else begin
      if (en) m_elapsed = (m_elapsed + 1) % 65536;
      m_tick = 1'b0; m_rise = 1'b0;
    end
  endtask

  // Compare process: on every falling edge check outputs, then advance model.
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      chk("clk_out", int'(clk_out), int'(m_clk));
      chk("tick", int'(tick), int'(m_tick));
      chk("rise", int'(rise), int'(m_rise));
      chk("div_ready", int'(div_bus.div_ready), int'(!m_pend_v));
`ifdef CLKDIV_OVS_EN
      chk("ovs_tick", int'(ovs_tick), int'(m_ovs_tick));
`endif
      if (!reset) model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_toggle(output int n);
    logic lvl;
    lvl = clk_out;
    n = 0;
    while (clk_out == lvl && n < 200) begin
      cyc();
      n++;
    end
    if (n >= 200) chk("toggle_timeout", n, 0);
  endtask

  initial begin
    int n;
    logic lvl;
    reset = 1'b1; en = 1'b0; sync = 1'b0;
    div_bus.div_in = 16'd0; div_bus.div_valid = 1'b0;

    chk("div_for_freq_9600", int'(div_for_freq(32'd9600)), 5208);
    chk("div_for_freq_0", int'(div_for_freq(32'd0)), 1);

    repeat (3) cyc();
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_ready", int'(div_bus.div_ready), 1);
    reset = 1'b0; en = 1'b1;

    // Default divisor 4: first rise after 4 edges, then 4-cycle halves.
    wait_toggle(n); chk("first_rise_cycles", n, 4);
    chk("first_rise_tick", int'(tick), 1);
    chk("first_rise_rise", int'(rise), 1);
    wait_toggle(n); chk("fall_cycles", n, 4);
    chk("fall_tick", int'(tick), 1);
    chk("fall_rise", int'(rise), 0);
    wait_toggle(n); chk("second_rise_cycles", n, 4);

    // Load 2 mid half-period: current half finishes at 4, then halves of 2.
    cyc();
    div_bus.div_in = 16'd2; div_bus.div_valid = 1'b1;
    cyc();
    div_bus.div_valid = 1'b0;
    chk("load2_ready_low", int'(div_bus.div_ready), 0);
    wait_toggle(n); chk("load2_remaining", n, 2);
    chk("load2_ready_back", int'(div_bus.div_ready), 1);
    wait_toggle(n); chk("div2_half_a", n, 2);
    wait_toggle(n); chk("div2_half_b", n, 2);

    // Transfer coincident with a wrap: applied there, ready never drops.
    cyc();
    lvl = clk_out;
    div_bus.div_in = 16'd6; div_bus.div_valid = 1'b1;
    cyc();
    div_bus.div_valid = 1'b0;
    chk("bypass_toggled", int'(clk_out != lvl), 1);
    chk("bypass_ready", int'(div_bus.div_ready), 1);
    wait_toggle(n); chk("div6_half", n, 6);

    // Divisor 0 clamps to 1.
    div_bus.div_in = 16'd0; div_bus.div_valid = 1'b1;
    cyc();
    div_bus.div_valid = 1'b0;
    chk("load0_ready_low", int'(div_bus.div_ready), 0);
    wait_toggle(n); chk("load0_remaining", n, 5);
    wait_toggle(n); chk("div1_half_a", n, 1);
    wait_toggle(n); chk("div1_half_b", n, 1);

    // Enable gap keeps the count; sync restarts the phase low.
    div_bus.div_in = 16'd8; div_bus.div_valid = 1'b1;
    cyc();
    div_bus.div_valid = 1'b0;
    chk("load8_ready", int'(div_bus.div_ready), 1);
    repeat (3) cyc();
    lvl = clk_out;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("en_off_hold", int'(clk_out), int'(lvl));
      chk("en_off_tick", int'(tick), 0);
    end
    en = 1'b1;
    wait_toggle(n); chk("en_resume_remaining", n, 5);
    repeat (2) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_clk_out", int'(clk_out), 0);
    chk("sync_tick", int'(tick), 0);
    wait_toggle(n); chk("sync_full_half", n, 8);

    // Reset with a divisor pending: everything back to reset values.
    cyc();
    div_bus.div_in = 16'd3; div_bus.div_valid = 1'b1;
    cyc();
    div_bus.div_valid = 1'b0;
    chk("pend_ready_low", int'(div_bus.div_ready), 0);
    cyc();
    reset = 1'b1;
    #1;
    chk("mid_rst_clk_out", int'(clk_out), 0);
    chk("mid_rst_tick", int'(tick), 0);
    chk("mid_rst_rise", int'(rise), 0);
    chk("mid_rst_ready", int'(div_bus.div_ready), 1);
    repeat (2) cyc();
    reset = 1'b0;
    wait_toggle(n); chk("post_rst_div", n, 4);

    // Randomized traffic, checked by the compare process.
    for (int i = 0; i < 4000; i++) begin
      cyc();
      en                = ($urandom_range(9) != 0);
      sync              = ($urandom_range(39) == 0);
      div_bus.div_valid = ($urandom_range(7) == 0);
      div_bus.div_in    = 16'($urandom_range(9));
      reset             = ($urandom_range(599) == 0);
    end
    reset = 1'b0; sync = 1'b0; div_bus.div_valid = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
